// File: rtl/mux21_4_rr_arb.sv
// Round-robin arbiter sharing one W-bit 2:1 mux between two requesters,
// with a one-entry valid/ready output register and per-requester grant counters.
module mux21_4_rr_arb #(
    parameter int W  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [W-1:0]  w0,
    output logic          ack0,
    input  logic          req1,
    input  logic [W-1:0]  w1,
    output logic          ack1,
    output logic [W-1:0]  y,
    output logic          y_valid,
    input  logic          y_ready,
    output logic          s,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   y_reg, y_next;
    logic           s_reg, s_next;
    logic           last_reg, last_next;
    logic [CW-1:0]  cnt_reg  [2];
    logic [CW-1:0]  cnt_next [2];
    logic [1:0]     req;
    logic [1:0]     ack;
    logic           free;
    logic           accept;
    logic           sel;

    assign req = {req1, req0};

    // Ties resolve against the most recent winner; last resets to 1 so
    // requester 0 wins the first contention.
    always_comb begin
        sel = 1'b0;
        if (req0 && req1) begin
            sel = ~last_reg;
        end else if (req1) begin
            sel = 1'b1;
        end
    end

    assign free   = (state_reg == EMPTY) | y_ready;
    assign accept = free & (req0 | req1);

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        s_next     = s_reg;
        last_next  = last_reg;
        if (accept) begin
            state_next = FULL;
            y_next     = sel ? w1 : w0;
            s_next     = sel;
            last_next  = sel;
        end else if ((state_reg == FULL) && y_ready) begin
            state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            y_reg     <= '0;
            s_reg     <= 1'b0;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            s_reg     <= s_next;
            last_reg  <= last_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            // Acks are gated by rst_n since they are combinational on req.
            assign ack[gi] = rst_n & accept & (sel == gi[0]);

            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (ack[gi]) begin
                    cnt_next[gi] = cnt_reg[gi] + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else begin
                    cnt_reg[gi] <= cnt_next[gi];
                end
            end
        end
    endgenerate

    assign ack0    = ack[0];
    assign ack1    = ack[1];
    assign y       = y_reg;
    assign y_valid = (state_reg == FULL);
    assign s       = s_reg;
    assign cnt0    = cnt_reg[0];
    assign cnt1    = cnt_reg[1];

endmodule

// File: tb/tb_mux21_4_rr_arb.sv
// Directed bench for mux21_4_rr_arb: reset, single requesters, contention,
// backpressure, drain, mid-stream reset and counter wrap.
module tb_mux21_4_rr_arb;

    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk;
    logic          rst_n;
    logic          req0, req1;
    logic [W-1:0]  w0, w1;
    logic          ack0, ack1;
    logic [W-1:0]  y;
    logic          y_valid;
    logic          y_ready;
    logic          s;
    logic [CW-1:0] cnt0, cnt1;

    int checks   = 0;
    int failures = 0;

    mux21_4_rr_arb #(.W(W), .CW(CW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .w0      (w0),
        .ack0    (ack0),
        .req1    (req1),
        .w1      (w1),
        .ack1    (ack1),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .s       (s),
        .cnt0    (cnt0),
        .cnt1    (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ack(input string tag, input logic a0, input logic a1);
        @(negedge clk);
        chk({tag, "_ack0"}, ack0, a0);
        chk({tag, "_ack1"}, ack1, a1);
        $display("cycle %s ack0=%0b ack1=%0b", tag, ack0, ack1);
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] ey, input logic es,
                           input logic ev, input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        chk({tag, "_y"}, y, ey);
        chk({tag, "_s"}, s, es);
        chk({tag, "_valid"}, y_valid, ev);
        chk({tag, "_cnt0"}, cnt0, c0);
        chk({tag, "_cnt1"}, cnt1, c1);
        $display("xfer %s y=%b s=%0b valid=%0b cnt0=%0d cnt1=%0d", tag, y, s, y_valid, cnt0, cnt1);
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b0; w0 = 4'd3; w1 = 4'd0; y_ready = 1'b1;

        // Reset: acks suppressed even with a request up
        chk_ack("reset", 1'b0, 1'b0);
        chk_out("reset", 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single requester 0, sweep w0 1..9
        req0 = 1'b1;
        for (int w = 1; w <= 9; w++) begin
            w0 = 4'(w);
            chk_ack("single0", 1'b1, 1'b0);
            tick();
            chk_out("single0", 4'(w), 1'b0, 1'b1, 8'(w), 8'd0);
        end

        // Single requester 1
        req0 = 1'b0; req1 = 1'b1; w1 = 4'b0111;
        chk_ack("single1", 1'b0, 1'b1);
        tick();
        chk_out("single1", 4'b0111, 1'b1, 1'b1, 8'd9, 8'd1);

        // Contention: last=1, so 0 wins first and grants alternate
        req0 = 1'b1; req1 = 1'b1; w0 = 4'b0111; w1 = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                chk_ack("cont", 1'b1, 1'b0);
                tick();
                chk_out("cont", 4'b0111, 1'b0, 1'b1, 8'(10 + i / 2), 8'(1 + i / 2));
            end else begin
                chk_ack("cont", 1'b0, 1'b1);
                tick();
                chk_out("cont", 4'b0010, 1'b1, 1'b1, 8'(10 + i / 2), 8'(2 + i / 2));
            end
        end

        // Load 0101 then hold off the consumer with req1 pending
        req1 = 1'b0; w0 = 4'b0101;
        chk_ack("load", 1'b1, 1'b0);
        tick();
        chk_out("load", 4'b0101, 1'b0, 1'b1, 8'd13, 8'd4);
        req0 = 1'b0; req1 = 1'b1; w1 = 4'b1010; y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk_ack("bp", 1'b0, 1'b0);
            tick();
            chk_out("bp", 4'b0101, 1'b0, 1'b1, 8'd13, 8'd4);
        end
        y_ready = 1'b1;
        chk_ack("bp_release", 1'b0, 1'b1);
        tick();
        chk_out("bp_release", 4'b1010, 1'b1, 1'b1, 8'd13, 8'd5);

        // Drain to empty; y holds; ready while empty is ignored
        req1 = 1'b0;
        chk_ack("drain", 1'b0, 1'b0);
        tick();
        chk_out("drain", 4'b1010, 1'b1, 1'b0, 8'd13, 8'd5);
        chk_ack("empty", 1'b0, 1'b0);
        tick();
        chk_out("empty", 4'b1010, 1'b1, 1'b0, 8'd13, 8'd5);

        // Mid-stream async reset with a word held
        req0 = 1'b1; w0 = 4'b0011; y_ready = 1'b0;
        chk_ack("pre_rst", 1'b1, 1'b0);
        tick();
        chk_out("pre_rst", 4'b0011, 1'b0, 1'b1, 8'd14, 8'd5);
        req0 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Counter wrap: 256 accepts from requester 0
        req0 = 1'b1; y_ready = 1'b1; w0 = 4'd6;
        repeat (255) tick();
        chk_out("wrap_255", 4'd6, 1'b0, 1'b1, 8'd255, 8'd0);
        tick();
        chk_out("wrap_0", 4'd6, 1'b0, 1'b1, 8'd0, 8'd0);
        req0 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux21_4_rr_arb.md
# mux21_4_rr_arb

Round-robin arbiter that shares one 4-bit 2:1 mux datapath between two requesters. Each requester presents a data word with a request; the arbiter drives the mux select, captures the selected word into a one-entry output register, and returns a one-cycle acknowledge to the winner. It sits in front of any consumer of the shared `y` bus and adds valid/ready backpressure plus per-requester grant counters.

## Interface
- `W`, 4, data width of `w0`, `w1`, `y`.
- `CW`, 8, width of the grant counters.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: requester 0 has a word on `w0`.
- `w0` input W: requester 0 data.
- `ack0` output 1: one-cycle pulse, `w0` accepted this cycle.
- `req1` input 1: requester 1 has a word on `w1`.
- `w1` input W: requester 1 data.
- `ack1` output 1: one-cycle pulse, `w1` accepted this cycle.
- `y` output W: registered output word.
- `y_valid` output 1: `y` holds an undelivered word.
- `y_ready` input 1: consumer takes `y` when `y_valid & y_ready`.
- `s` output 1: registered select of the word in `y` (0 = `w0`, 1 = `w1`).
- `cnt0` output CW: number of words accepted from requester 0, wraps.
- `cnt1` output CW: number of words accepted from requester 1, wraps.

## Operation
- Requester protocol: once `req_i` rises, `req_i` and `w_i` stay stable until the cycle `ack_i` is high; deassertion without ack is a protocol violation (behaviour unspecified, not checked).
- Two states, encoded by `y_valid`: EMPTY (0), FULL (1).
- `free = ~y_valid | y_ready` (slot empty or being drained this cycle).
- `accept = free & (req0 | req1)`.
- Arbitration (combinational, evaluated every cycle): only `req0` -> sel 0; only `req1` -> sel 1; both -> sel = ~`last`. `last` is an internal flop holding the most recently granted index.
- On `accept`: `ack_sel` = 1 same cycle (Mealy, combinational); at the clock edge `y` <= `w_sel`, `s` <= sel, `last` <= sel, `y_valid` <= 1, `cnt_sel` <= `cnt_sel` + 1 (mod 2^CW).
- No accept and `y_valid & y_ready`: `y_valid` <= 0; `y`, `s` hold their last values.
- No accept and not draining: all registers hold.
- Transitions: EMPTY -> FULL on accept; FULL -> FULL on accept (simultaneous drain and refill); FULL -> EMPTY on `y_ready` with no request; FULL holds while `y_ready` = 0.
- `ack0` and `ack1` are never high in the same cycle; neither is high when `free` = 0.
- `y_ready` while EMPTY is ignored.

## Timing
- Reset (async assert, sync-safe deassert by the system): `y` = 0, `y_valid` = 0, `s` = 0, `last` = 1, `cnt0` = `cnt1` = 0; `ack0` = `ack1` = 0 while `rst_n` = 0. With `last` = 1, requester 0 wins the first contention.
- Reset mid-operation discards the word in `y` and any pending grant; requesters re-present after reset.
- Latency: request seen with `free` = 1 -> ack same cycle -> word on `y` with `y_valid` = 1 after the next rising edge (1 cycle).
- Throughput: one word per cycle with `y_ready` held high; under continuous dual requests grants alternate 0,1,0,1.
- Backpressure: with `y_ready` = 0 and FULL, no ack issues; `y`, `s`, counters frozen.
- Counter wrap: `cnt_i` = 2^CW-1 plus one accept -> 0; no saturation, no flag.

## Test plan
- Reset: drive `rst_n` = 0 mid-stream with `y_valid` = 1 -> `y` = 0, `y_valid` = 0, `s` = 0, counters 0 immediately (before next edge).
- Single requester: `req0` = 1, `w0` = 4'b0001, `y_ready` = 1 -> `ack0` same cycle, next cycle `y` = 4'b0001, `s` = 0, `cnt0` = 1; sweep `w0` 1..9 likewise with `req1`, `w1` = 4'b0111 -> `y` tracks `w1`, `s` = 1.
- Contention: `req0` = `req1` = 1 held, `w0` = 4'b0111, `w1` = 4'b0010, `y_ready` = 1 for 6 cycles -> `y` sequence 0111,0010,0111,0010,0111,0010, `cnt0` = `cnt1` = 3, acks never overlap.
- Backpressure: FULL with `y` = 4'b0101, `y_ready` = 0 for 5 cycles, `req1` = 1 -> `y` stays 0101, no `ack1`; raise `y_ready` -> `ack1` that cycle, new word next cycle, no gap.
- Drain to empty: one word delivered, requests low, `y_ready` = 1 -> `y_valid` falls after one edge, `y` keeps last value.
- Wrap: with `CW` = 8, 256 accepts from requester 0 -> `cnt0` = 0.
